// File: rtl/udp_tx_framer.sv
// UDP/IPv4/Ethernet transmit framer: one 42-byte header beat, then the payload passed through.
// Optional macro UDP_TX_IPCSUM_EN adds a one-cycle CSUM state that fills in the IPv4 header checksum.
module udp_tx_framer #(
  parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
  parameter logic [15:0] SRC_PORT = 16'd5000,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [47:0]  req_dst_mac,
  input  logic [31:0]  req_dst_ip,
  input  logic [15:0]  req_dst_port,
  input  logic [15:0]  req_len,
  input  logic [511:0] in_data,
  input  logic [63:0]  in_keep,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] out_data,
  output logic [63:0]  out_keep,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  frames_sent,
  output logic         len_err
);
  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam logic [KEEP_W-1:0] HDR_KEEP = 64'h0000_03FF_FFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_CSUM, S_HDR, S_PAY} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [47:0]        r_dst_mac;
  logic [31:0]        r_dst_ip;
  logic [15:0]        r_dst_port;
  logic [15:0]        r_len;
  logic [15:0]        r_id;
  logic [15:0]        r_byte_cnt;
  logic [31:0]        r_frames;
  logic               r_len_err;
  logic [15:0]        w_csum;
  logic [DATA_W-1:0]  w_hdr_base;
  logic [DATA_W-1:0]  w_hdr;
  logic               w_accept;
  logic               w_beat_xfer;
  logic [15:0]        w_byte_total;

  function automatic logic [6:0] popcount(input logic [KEEP_W-1:0] keep);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_W; i++) cnt = cnt + {6'd0, keep[i]};
    return cnt;
  endfunction

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_beat_xfer  = (r_state == S_PAY) && in_valid && out_ready;
  assign w_byte_total = r_byte_cnt + {9'd0, popcount(in_keep)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) begin
`ifdef UDP_TX_IPCSUM_EN
        w_next = S_CSUM;
`else
        w_next = S_HDR;
`endif
      end
      S_CSUM: w_next = S_HDR;
      S_HDR:  if (out_ready) w_next = (r_len == 16'd0) ? S_IDLE : S_PAY;
      S_PAY:  if (in_valid && out_ready && in_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_keep  = '0;
    out_data  = '0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_HDR: begin
        out_valid = 1'b1;
        out_keep  = HDR_KEEP;
        out_last  = (r_len == 16'd0);
        out_data  = w_hdr;
      end
      S_PAY: begin
        out_valid = in_valid;
        out_keep  = in_keep;
        out_last  = in_last;
        out_data  = in_data;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Request fields hold the header steady through any output stall.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dst_mac  <= req_dst_mac;
      r_dst_ip   <= req_dst_ip;
      r_dst_port <= req_dst_port;
      r_len      <= req_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id       <= '0;
      r_byte_cnt <= '0;
      r_frames   <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (r_state == S_HDR && out_ready) r_id <= r_id + 16'd1;
      if (w_accept)         r_byte_cnt <= '0;
      else if (w_beat_xfer) r_byte_cnt <= w_byte_total;
      if (out_valid && out_ready && out_last) r_frames <= r_frames + 32'd1;
      r_len_err <= w_beat_xfer && in_last && (w_byte_total != r_len);
    end
  end

  always_comb begin
    w_hdr_base            = '0;
    w_hdr_base[47:0]      = r_dst_mac;
    w_hdr_base[95:48]     = SRC_MAC;
    w_hdr_base[111:96]    = 16'h0800;
    w_hdr_base[115:112]   = 4'd4;
    w_hdr_base[119:116]   = 4'd5;
    w_hdr_base[143:128]   = r_len + 16'd28;
    w_hdr_base[159:144]   = r_id;
    w_hdr_base[183:176]   = TTL;
    w_hdr_base[191:184]   = 8'd17;
    w_hdr_base[239:208]   = SRC_IP;
    w_hdr_base[271:240]   = r_dst_ip;
    w_hdr_base[287:272]   = SRC_PORT;
    w_hdr_base[303:288]   = r_dst_port;
    w_hdr_base[319:304]   = r_len + 16'd8;
    w_hdr                 = w_hdr_base;
    w_hdr[207:192]        = w_csum;
  end

`ifdef UDP_TX_IPCSUM_EN
  logic [15:0] r_csum;

  // Ten 16-bit words of the IPv4 header (bits 271:112), end-around carry folded twice.
  function automatic logic [15:0] ip_csum(input logic [159:0] ip);
    logic [19:0] sum;
    sum = '0;
    for (int k = 0; k < 10; k++) sum = sum + {4'd0, ip[16*k +: 16]};
    sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
    sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
    return ~sum[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (r_state == S_CSUM) r_csum <= ip_csum(w_hdr_base[271:112]);
  end
  assign w_csum = r_csum;
`else
  assign w_csum = 16'h0000;
`endif

  assign frames_sent = r_frames;
  assign len_err     = r_len_err;
endmodule

// File: tb/tb_udp_tx_framer.sv
// Bench for udp_tx_framer: directed vector table, reset corner cases and random frames vs a reference model.
module tb_udp_tx_framer;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [47:0]  req_dst_mac;
  logic [31:0]  req_dst_ip;
  logic [15:0]  req_dst_port;
  logic [15:0]  req_len;
  logic [511:0] in_data;
  logic [63:0]  in_keep;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] out_data;
  logic [63:0]  out_keep;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  frames_sent;
  logic         len_err;

  udp_tx_framer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_mac(req_dst_mac), .req_dst_ip(req_dst_ip),
    .req_dst_port(req_dst_port), .req_len(req_len),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .frames_sent(frames_sent), .len_err(len_err)
  );

  always #5 clk = ~clk;

`ifdef UDP_TX_IPCSUM_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] len;
    int          nb;
    int          b0;
    int          b1;
    int          hold;
    logic [15:0] exp_tot;
    logic [15:0] exp_udp;
    logic        exp_err;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_id = 16'd0;
  logic [31:0] m_frames = 32'd0;
  int          q_beats[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [63:0] keep_of(input int n);
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // One's-complement sum of the ten IPv4 header words, not complemented.
  function automatic logic [15:0] ones_sum(input logic [511:0] h);
    int unsigned acc;
    acc = 0;
    for (int w = 0; w < 10; w++) acc += int'(h[112 + 16*w +: 16]);
    while (acc > 32'hFFFF) acc = (acc & 32'hFFFF) + (acc >> 16);
    return acc[15:0];
  endfunction

  function automatic logic [511:0] model_hdr(input logic [47:0] mac, input logic [31:0] ip,
      input logic [15:0] port, input logic [15:0] tot, input logic [15:0] udp, input logic [15:0] id);
    logic [511:0] h;
    h = '0;
    h[47:0]    = mac;
    h[95:48]   = 48'h02_00_00_00_00_01;
    h[111:96]  = 16'h0800;
    h[119:112] = 8'h54;
    h[143:128] = tot;
    h[159:144] = id;
    h[183:176] = 8'd64;
    h[191:184] = 8'd17;
    h[239:208] = 32'hC0A8_0001;
    h[271:240] = ip;
    h[287:272] = 16'd5000;
    h[303:288] = port;
    h[319:304] = udp;
`ifdef UDP_TX_IPCSUM_EN
    h[207:192] = ~ones_sum(h);
`endif
    return h;
  endfunction

  task automatic run_frame(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port,
      input logic [15:0] len, input int hold, input logic [15:0] exp_tot,
      input logic [15:0] exp_udp, input logic exp_err);
    logic [511:0] exp_h;
    int lat, idx, cyc, nb;
    nb = q_beats.size();
    exp_h = model_hdr(mac, ip, port, exp_tot, exp_udp, m_id);
    @(negedge clk);
    req_dst_mac = mac; req_dst_ip = ip; req_dst_port = port; req_len = len;
    req_valid = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    #1 chk("req_ready_idle", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_dst_mac = {16'($urandom), $urandom}; req_dst_ip = $urandom;
    req_dst_port = 16'($urandom); req_len = 16'($urandom);
    #1 lat = 1;
    while (!out_valid && lat < 8) begin
      chk("req_ready_busy", req_ready, 1'b0);
      @(negedge clk); #1 lat++;
    end
    if (!out_valid) begin
      chk("hdr_timeout", out_valid, 1'b1);
      finish_run();
    end
    chk("hdr_latency", lat, EXP_LAT);
    for (int h = 0; h < hold; h++) begin
      chk("hdr_stall_data", out_data, exp_h);
      chk("hdr_stall_keep", out_keep, 64'h0000_03FF_FFFF_FFFF);
      chk("hdr_stall_valid", out_valid, 1'b1);
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("hdr_data", out_data, exp_h);
    chk("hdr_keep", out_keep, 64'h0000_03FF_FFFF_FFFF);
    chk("hdr_last", out_last, len == 16'd0);
    chk("hdr_in_ready", in_ready, 1'b0);
`ifdef UDP_TX_IPCSUM_EN
    chk("hdr_csum_sum", ones_sum(out_data), 16'hFFFF);
`endif
    @(posedge clk);
    m_id++;
    if (len == 16'd0) m_frames++;
    if (nb == 0) begin
      @(negedge clk); in_valid = 1'b0;
      #1;
      chk("nopay_in_ready", in_ready, 1'b0);
      chk("nopay_req_ready", req_ready, 1'b1);
      chk("nopay_out_valid", out_valid, 1'b0);
      chk("nopay_frames", frames_sent, m_frames);
      chk("nopay_len_err", len_err, 1'b0);
      return;
    end
    idx = 0; cyc = 0;
    while (idx < nb && cyc < 300) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_data   = rand_data();
      in_keep   = keep_of(q_beats[idx]);
      in_last   = (idx == nb - 1);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("pay_valid", out_valid, in_valid);
      chk("pay_data", out_data, in_data);
      chk("pay_keep", out_keep, in_keep);
      chk("pay_last", out_last, in_last);
      chk("pay_in_ready", in_ready, out_ready);
      if (in_valid && out_ready) begin
        idx++;
        if (in_last) m_frames++;
      end
      cyc++;
    end
    if (idx < nb) begin
      chk("pay_timeout", idx, nb);
      finish_run();
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("end_len_err", len_err, exp_err);
    chk("end_frames", frames_sent, m_frames);
    chk("end_req_ready", req_ready, 1'b1);
    chk("end_out_valid", out_valid, 1'b0);
    @(negedge clk); #1;
    chk("len_err_pulse", len_err, 1'b0);
  endtask

  vec_t tbl[5];

  initial begin
    int len, rem, sum;
    logic err;
    tbl[0] = '{48'hAABBCCDDEEFF, 32'h0A000005, 16'd4791, 16'd64, 1, 64, 0, 0, 16'd92, 16'd72, 1'b0};
    tbl[1] = '{48'h112233445566, 32'hC0A80164, 16'd53, 16'd0, 0, 0, 0, 1, 16'd28, 16'd8, 1'b0};
    tbl[2] = '{48'h010203040506, 32'h0A0A0A0A, 16'd1234, 16'd100, 2, 64, 30, 0, 16'd128, 16'd108, 1'b1};
    tbl[3] = '{48'hDEADBEEF0001, 32'h08080808, 16'd80, 16'd10, 1, 10, 0, 5, 16'd38, 16'd18, 1'b0};
    tbl[4] = '{48'hFFFFFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFF0, 1, 64, 0, 2, 16'h000C, 16'hFFF8, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_dst_mac = '0; req_dst_ip = '0; req_dst_port = '0;
    req_len = '0; in_data = '0; in_keep = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_keep", out_keep, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_frames", frames_sent, 32'd0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);

    for (int v = 0; v < 5; v++) begin
      q_beats.delete();
      if (tbl[v].nb > 0) q_beats.push_back(tbl[v].b0);
      if (tbl[v].nb > 1) q_beats.push_back(tbl[v].b1);
      run_frame(tbl[v].mac, tbl[v].ip, tbl[v].port, tbl[v].len, tbl[v].hold,
                tbl[v].exp_tot, tbl[v].exp_udp, tbl[v].exp_err);
    end

    // Reset in the middle of a payload: frame abandoned, ID and counters restart.
    @(negedge clk);
    req_dst_mac = 48'h0A0B0C0D0E0F; req_dst_ip = 32'h01020304; req_dst_port = 16'd9;
    req_len = 16'd128; req_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    for (int k = 0; k < 8 && !out_valid; k++) begin
      @(negedge clk); #1;
    end
    chk("mid_hdr_valid", out_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_keep = '1; in_last = 1'b0; in_data = rand_data();
    #1 chk("mid_pay_valid", out_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_last", out_last, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_frames", frames_sent, 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_id = 16'd0; m_frames = 32'd0;
    #1 chk("mid_rel_req_ready", req_ready, 1'b1);
    q_beats.delete();
    q_beats.push_back(64);
    run_frame(48'hAABBCCDDEEFF, 32'h0A000005, 16'd4791, 16'd64, 0, 16'd92, 16'd72, 1'b0);

    for (int f = 0; f < 25; f++) begin
      len = (f % 6 == 0) ? 0 : $urandom_range(1, 300);
      q_beats.delete();
      rem = len;
      while (rem > 64) begin
        q_beats.push_back(64);
        rem -= 64;
      end
      if (len > 0) q_beats.push_back(rem);
      if (len > 0 && $urandom_range(0, 3) == 0)
        q_beats[q_beats.size() - 1] = $urandom_range(1, 64);
      sum = 0;
      foreach (q_beats[i]) sum += q_beats[i];
      err = (sum != len);
      run_frame({16'($urandom), $urandom}, $urandom, 16'($urandom), 16'(len),
                $urandom_range(0, 3), 16'(len + 28), 16'(len + 8), err);
    end

    finish_run();
  end
endmodule
